// File: rtl/pll_lock_monitor.sv
// PLL lock monitor: measures clk_i cycles between synchronised ref_i rising edges and
// declares lock after GOOD_PERIODS consecutive in-tolerance periods.
module pll_lock_monitor #(
    parameter int EXP_COUNT    = 16,
    parameter int TOL          = 1,
    parameter int GOOD_PERIODS = 4,
    parameter int TIMEOUT      = 32,
    parameter int CNT_W        = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             ref_i,
    output logic             lock_o,
    output logic             err_o,
    output logic [CNT_W-1:0] period_o,
    output logic             period_valid_o,
    output logic [7:0]       loss_cnt_o,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int GC_W = $clog2(GOOD_PERIODS + 1);
    localparam logic [CNT_W:0]   LO_LIM  = (CNT_W+1)'(EXP_COUNT - TOL);
    localparam logic [CNT_W:0]   HI_LIM  = (CNT_W+1)'(EXP_COUNT + TOL);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [GC_W-1:0]  GC_LAST = GC_W'(GOOD_PERIODS - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    logic [GC_W-1:0]  r_good_cnt;
    logic             r_lock;
    logic             r_err;
    logic             r_pv;
    logic [CNT_W-1:0] r_period;
    logic [7:0]       r_loss;

    logic             w_rise;
    logic             w_good;
    logic             w_timeout;
    logic [CNT_W-1:0] w_cnt_nxt;
    state_t           w_state_nxt;
    logic [GC_W-1:0]  w_gc_nxt;
    logic             w_lock_nxt;
    logic             w_err_nxt;
    logic             w_pv_nxt;
    logic [CNT_W-1:0] w_period_nxt;
    logic [7:0]       w_loss_nxt;

    // r_sync2 is the edge register; a rise is seen once the level reaches r_sync1.
    assign w_rise    = r_sync1 & ~r_sync2;
    assign w_good    = ({1'b0, r_cnt} >= LO_LIM) && ({1'b0, r_cnt} <= HI_LIM);
    assign w_timeout = (r_cnt == TO_VAL) && !w_rise;
    assign w_cnt_nxt = w_rise ? CNT_W'(1) : ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1));

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_sync0    <= 1'b0;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_cnt      <= '0;
            r_state    <= ST_IDLE;
            r_good_cnt <= '0;
            r_lock     <= 1'b0;
            r_err      <= 1'b0;
            r_pv       <= 1'b0;
            r_period   <= '0;
            r_loss     <= '0;
        end else begin
            r_sync0    <= ref_i;
            r_sync1    <= r_sync0;
            r_sync2    <= r_sync1;
            r_cnt      <= w_cnt_nxt;
            r_state    <= w_state_nxt;
            r_good_cnt <= w_gc_nxt;
            r_lock     <= w_lock_nxt;
            r_err      <= w_err_nxt;
            r_pv       <= w_pv_nxt;
            r_period   <= w_period_nxt;
            r_loss     <= w_loss_nxt;
        end
    end

    // A rise always takes priority over the timeout on the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_gc_nxt    = r_good_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_TRACK;
                    w_gc_nxt    = '0;
                end
            end
            ST_TRACK: begin
                if (w_rise) begin
                    if (w_good) begin
                        w_gc_nxt = r_good_cnt + GC_W'(1);
                        if (r_good_cnt == GC_LAST) begin
                            w_state_nxt = ST_LOCKED;
                        end
                    end else begin
                        w_gc_nxt = '0;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_gc_nxt    = '0;
                end
            end
            ST_LOCKED: begin
                if (w_rise) begin
                    if (!w_good) begin
                        w_state_nxt = ST_TRACK;
                        w_gc_nxt    = '0;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_gc_nxt    = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gc_nxt    = '0;
            end
        endcase
    end

    always_comb begin
        w_lock_nxt   = (w_state_nxt == ST_LOCKED);
        w_err_nxt    = (r_state == ST_LOCKED) && (w_state_nxt != ST_LOCKED);
        w_pv_nxt     = w_rise && (r_state != ST_IDLE);
        w_period_nxt = w_pv_nxt ? r_cnt : r_period;
        w_loss_nxt   = r_loss;
        if (w_err_nxt && (r_loss != 8'hFF)) begin
            w_loss_nxt = r_loss + 8'd1;
        end
    end

    assign lock_o         = r_lock;
    assign err_o          = r_err;
    assign period_o       = r_period;
    assign period_valid_o = r_pv;
    assign loss_cnt_o     = r_loss;
    assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: an edge-timeline model checked every cycle, plus
// hand-computed literal expectations per scenario.
module tb_pll_lock_monitor;

    localparam int EXP_COUNT    = 16;
    localparam int TOL          = 1;
    localparam int GOOD_PERIODS = 4;
    localparam int TIMEOUT      = 32;
    localparam int CNT_W        = 8;

    logic             clk_i;
    logic             rstn_i;
    logic             ref_i;
    logic             lock_o;
    logic             err_o;
    logic [CNT_W-1:0] period_o;
    logic             period_valid_o;
    logic [7:0]       loss_cnt_o;
    logic [1:0]       dbg_state_o;

    int checks = 0;
    int errors = 0;

    pll_lock_monitor #(
        .EXP_COUNT(EXP_COUNT), .TOL(TOL), .GOOD_PERIODS(GOOD_PERIODS),
        .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .ref_i(ref_i),
        .lock_o(lock_o), .err_o(err_o), .period_o(period_o),
        .period_valid_o(period_valid_o), .loss_cnt_o(loss_cnt_o),
        .dbg_state_o(dbg_state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: works on edge numbers. A ref level sampled at edge n becomes a rise at edge n+2
    // (acted on at the 3rd edge); the elapsed count is edges since the last rise or reset.
    int   n_cyc = 0;
    int   anchor = 0;
    bit   model_ok = 0;
    bit   have_prev, m_locked;
    int   run;
    bit   d1, d2, d3;
    logic m_err, m_pv;
    logic [7:0] m_period, m_loss;

    always @(posedge clk_i) begin
        int  el;
        bit  rise;
        n_cyc++;
        if (!rstn_i) begin
            model_ok = 1; anchor = n_cyc + 1;
            have_prev = 0; m_locked = 0; run = 0;
            d1 = 0; d2 = 0; d3 = 0;
            m_err = 0; m_pv = 0; m_period = 0; m_loss = 0;
        end else if (model_ok) begin
            el = n_cyc - anchor;
            if (el > 255) el = 255;
            rise = d2 && !d3;
            m_err = 0; m_pv = 0;
            if (rise) begin
                if (have_prev) begin
                    m_pv = 1;
                    m_period = el[7:0];
                    if (el >= EXP_COUNT - TOL && el <= EXP_COUNT + TOL) begin
                        if (!m_locked) begin
                            run++;
                            if (run == GOOD_PERIODS) m_locked = 1;
                        end
                    end else begin
                        if (m_locked) begin
                            m_err = 1;
                            if (m_loss != 8'd255) m_loss++;
                        end
                        m_locked = 0; run = 0;
                    end
                end
                have_prev = 1; anchor = n_cyc;
            end else if (el == TIMEOUT) begin
                if (m_locked) begin
                    m_err = 1;
                    if (m_loss != 8'd255) m_loss++;
                end
                m_locked = 0; run = 0; have_prev = 0;
            end
            d3 = d2; d2 = d1; d1 = ref_i;
        end
    end

    // Per-cycle compare plus event counters used by the literal checks.
    int   pv_total = 0;
    int   err_total = 0;
    int   lock_rise_pv = 0;
    logic prev_lock = 0;

    always @(negedge clk_i) begin
        if (model_ok) begin
            chk("lock_o", 32'(lock_o), 32'(m_locked));
            chk("err_o", 32'(err_o), 32'(m_err));
            chk("period_valid_o", 32'(period_valid_o), 32'(m_pv));
            chk("period_o", 32'(period_o), 32'(m_period));
            chk("loss_cnt_o", 32'(loss_cnt_o), 32'(m_loss));
            chk("dbg_state_o", 32'(dbg_state_o), m_locked ? 32'd2 : (have_prev ? 32'd1 : 32'd0));
            if (period_valid_o === 1'b1) pv_total++;
            if (err_o === 1'b1) err_total++;
            if (lock_o === 1'b1 && prev_lock !== 1'b1) lock_rise_pv = pv_total;
            prev_lock = lock_o;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
        #1;
    endtask

    task automatic pulse(input int p);
        ref_i = 1'b1;
        step(p / 2);
        ref_i = 1'b0;
        step(p - p / 2);
    endtask

    task automatic do_reset(input int n);
        rstn_i = 1'b0;
        step(n);
        rstn_i = 1'b1;
    endtask

    int snap_pv, snap_err;

    task automatic snap();
        snap_pv  = pv_total;
        snap_err = err_total;
    endtask

    initial begin
        rstn_i = 1'b0;
        ref_i  = 1'b0;
        step(3);
        chk("reset lock", 32'(lock_o), 0);
        chk("reset err", 32'(err_o), 0);
        chk("reset pv", 32'(period_valid_o), 0);
        chk("reset period", 32'(period_o), 0);
        chk("reset loss", 32'(loss_cnt_o), 0);
        rstn_i = 1'b1;

        // ref stuck low from reset
        snap();
        step(300);
        chk("stuck lock", 32'(lock_o), 0);
        chk("stuck pv count", 32'(pv_total - snap_pv), 0);
        chk("stuck err count", 32'(err_total - snap_err), 0);

        // steady 16
        snap();
        for (int i = 0; i < 6; i++) pulse(16);
        chk("s16 lock", 32'(lock_o), 1);
        chk("s16 pv at lock", 32'(lock_rise_pv - snap_pv), 4);
        chk("s16 pv count", 32'(pv_total - snap_pv), 5);
        chk("s16 period", 32'(period_o), 16);

        // one long period while locked, then relock
        snap();
        pulse(20);
        for (int i = 0; i < 5; i++) pulse(16);
        chk("p20 loss", 32'(loss_cnt_o), 1);
        chk("p20 err count", 32'(err_total - snap_err), 1);
        chk("p20 relock", 32'(lock_o), 1);

        // reference lost while locked
        step(40);
        chk("lost lock", 32'(lock_o), 0);
        chk("lost loss", 32'(loss_cnt_o), 2);
        chk("lost state", 32'(dbg_state_o), 0);
        snap();
        for (int i = 0; i < 5; i++) pulse(16);
        chk("lost pv count", 32'(pv_total - snap_pv), 4);
        chk("lost pv at lock", 32'(lock_rise_pv - snap_pv), 4);
        chk("lost relock", 32'(lock_o), 1);

        pulse(20);
        for (int i = 0; i < 5; i++) pulse(16);
        chk("third loss", 32'(loss_cnt_o), 3);

        // 1-cycle reset while locked
        rstn_i = 1'b0;
        step(1);
        chk("midrst lock", 32'(lock_o), 0);
        chk("midrst err", 32'(err_o), 0);
        chk("midrst pv", 32'(period_valid_o), 0);
        chk("midrst period", 32'(period_o), 0);
        chk("midrst loss", 32'(loss_cnt_o), 0);
        rstn_i = 1'b1;
        snap();
        for (int i = 0; i < 5; i++) pulse(16);
        chk("midrst pv at lock", 32'(lock_rise_pv - snap_pv), 4);
        chk("midrst relock", 32'(lock_o), 1);

        // alternating 15/17
        do_reset(2);
        snap();
        for (int i = 0; i < 6; i++) pulse((i % 2 == 0) ? 15 : 17);
        chk("alt lock", 32'(lock_o), 1);
        chk("alt pv at lock", 32'(lock_rise_pv - snap_pv), 4);
        chk("alt period", 32'(period_o), 15);

        // steady 18 and steady 14: out of tolerance on both sides
        do_reset(2);
        snap();
        for (int i = 0; i < 6; i++) pulse(18);
        chk("p18 lock", 32'(lock_o), 0);
        chk("p18 period", 32'(period_o), 18);
        chk("p18 pv count", 32'(pv_total - snap_pv), 5);
        do_reset(2);
        for (int i = 0; i < 6; i++) pulse(14);
        chk("p14 lock", 32'(lock_o), 0);
        chk("p14 period", 32'(period_o), 14);

        // period of exactly TIMEOUT: the rise wins
        do_reset(2);
        snap();
        for (int i = 0; i < 3; i++) pulse(32);
        chk("p32 pv count", 32'(pv_total - snap_pv), 2);
        chk("p32 period", 32'(period_o), 32);

        // one past TIMEOUT: every period times out first
        do_reset(2);
        snap();
        for (int i = 0; i < 3; i++) pulse(33);
        chk("p33 pv count", 32'(pv_total - snap_pv), 0);

        // loss counter saturation
        do_reset(2);
        for (int i = 0; i < 5; i++) pulse(16);
        snap();
        for (int k = 0; k < 260; k++) begin
            pulse(20);
            for (int i = 0; i < 4; i++) pulse(16);
        end
        pulse(16);
        chk("sat loss", 32'(loss_cnt_o), 255);
        chk("sat err count", 32'(err_total - snap_err), 260);
        chk("sat relock", 32'(lock_o), 1);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
